cuppa_trigger_nch: RTL and testbench
====================================

# cuppa_trigger_nch

Parametrised N-channel trigger block for the wdc zedboard prototype. It sits between the ADC capture front end and the waveform buffer/readout logic and forwards each ADC stream with one cycle of delay. It issues a single-cycle trigger with a source code from one of three sources: external trigger, software run edge, or a k-of-N threshold coincidence. After each trigger an optional programmable holdoff blocks all trigger sources.

## Interface
Parameters:
- N_CHAN, 4, number of ADC channels (1..16)
- DATA_W, 12, sample width in bits
- HOLDOFF_W, 16, holdoff counter width
- K_W, $clog2(N_CHAN+1), width of coincidence threshold

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- adc_stream_in  in  N_CHAN*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- adc_stream_out  out  N_CHAN*DATA_W  adc_stream_in delayed one cycle
- gt, et, lt  in  1 each  comparator mode; sample s matches if (gt && s>thr) || (et && s==thr) || (lt && s<thr)
- thr  in  DATA_W  threshold, unsigned
- chan_en  in  N_CHAN  per-channel participation in the threshold trigger
- coinc_k  in  K_W  minimum number of enabled channels matching; 0 is treated as 1
- thresh_trig_en  in  1  enables the threshold source
- ext_trig_en  in  1  enables the external source
- ext_run  in  1  external trigger level; rising edge is the event
- run  in  1  software run level; rising edge is the event
- holdoff  in  HOLDOFF_W  dead time in cycles after a trigger
- trig  out  1  single-cycle trigger pulse
- trig_src  out  2  0 none, 1 threshold, 2 external, 3 software; valid while trig=1, else 0
- trig_chans  out  N_CHAN  enabled matching channels at the trigger sample; held until the next trigger
- thresh_tot  out  N_CHAN  registered per-channel match, unmasked by chan_en
- busy  out  1  holdoff active

## Operation
- Match vector: m[c] = comparator result for channel c. Enabled match: em = m & chan_en. Popcount of em is compared unsigned against max(coinc_k,1).
- Coincidence condition: cond = thresh_trig_en && popcount(em) >= max(coinc_k,1). Register cond_q <= cond every cycle, including during holdoff.
- Threshold event: cond && !cond_q. Only the rising edge of the condition counts, so a sustained over-threshold produces one trigger.
- External event: ext_trig_en && ext_run && !ext_run_q. Software event: run && !run_q. Both edge registers update every cycle.
- Priority: external > threshold > software. Only the winning source is reported; losing events in the same cycle are dropped.
- Holdoff counter hcnt:
  - On a trigger, hcnt <= holdoff.
  - Otherwise, if hcnt != 0, hcnt decrements.
  - busy = (hcnt != 0).
  - While busy, no source may trigger and events are discarded, not queued.
- trig_chans <= em on each trigger only.
- Reset values: adc_stream_out=0, trig=0, trig_src=0, trig_chans=0, thresh_tot=0, busy=0, hcnt=0.
- Edge registers reset to 0, so a level already high when reset releases counts as an edge on the first clock.

## Timing
- Sample on adc_stream_in at edge T:
  - It appears on adc_stream_out at T+1.
  - thresh_tot reflects it at T+1.
  - A threshold trigger caused by it asserts trig at T+1, aligned with that sample on adc_stream_out.
- If ext_run or run is first sampled high at edge T, trig asserts at T+1.
- If trig is high at cycle T, busy is high from T+1 through T+holdoff. The next trigger can be issued at T+holdoff+1 at the earliest.
- holdoff=0: busy never asserts, and back-to-back triggers are legal on consecutive cycles.
- holdoff written while busy takes effect at the next trigger only.
- If rst_n is asserted mid-holdoff or mid-pulse, all outputs clear immediately and asynchronously. There is no trigger on the first edge after deassertion unless an input edge rule fires.

## Configuration
- TRIG_HOLDOFF_EN defined: holdoff counter is built as described.
- TRIG_HOLDOFF_EN undefined:
  - No counter is synthesised and the holdoff port is ignored.
  - busy is tied to 0.
  - Triggers are limited only by the edge rules.

## Test plan
- N_CHAN=4, thr=100, gt=1, chan_en=4'hF, coinc_k=2: ch0 goes to 150 at T, ch1 goes to 150 at T+3 -> single trig, src=1, at T+4, trig_chans=4'b0011, no retrigger while both stay high.
- coinc_k=0, chan_en=4'b0100, only ch2 crosses -> trig src=1, trig_chans=4'b0100. Same stimulus with chan_en=0 -> no trig, but thresh_tot[2]=1.
- ext_run rises with ext_trig_en=1 in the same cycle as run rises and a threshold edge occurs -> one pulse, src=2. The run and threshold events are lost.
- TRIG_HOLDOFF_EN, holdoff=10: ext trigger at T, run edge at T+5 -> dropped, busy high T+1..T+10. Run edge at T+11 -> trig at T+12, src=3.
- holdoff=0, ext_run toggling every cycle -> trig on every second cycle, busy always 0.
- Assert rst_n low at T+3 of a 10-cycle holdoff -> busy, trig, trig_src, trig_chans, adc_stream_out all 0 asynchronously. After release, a run edge triggers without holdoff delay.

Source files
------------

// File: rtl/cuppa_trigger_nch_if.sv
// cuppa_trigger_nch_if
//   Bundles the ADC data path, trigger configuration and trigger result
//   signals of cuppa_trigger_nch. Clock and reset stay outside.
//   master : capture front end / control side (drives ADC samples and config)
//   slave  : the trigger block (drives delayed samples and trigger results)
interface cuppa_trigger_nch_if #(
    parameter int N_CHAN    = 4,
    parameter int DATA_W    = 12,
    parameter int HOLDOFF_W = 16,
    parameter int K_W       = $clog2(N_CHAN + 1)
);
    logic [N_CHAN*DATA_W-1:0] adc_stream_in;
    logic [N_CHAN*DATA_W-1:0] adc_stream_out;
    logic                     gt;
    logic                     et;
    logic                     lt;
    logic [DATA_W-1:0]        thr;
    logic [N_CHAN-1:0]        chan_en;
    logic [K_W-1:0]           coinc_k;
    logic                     thresh_trig_en;
    logic                     ext_trig_en;
    logic                     ext_run;
    logic                     run;
    logic [HOLDOFF_W-1:0]     holdoff;
    logic                     trig;
    logic [1:0]               trig_src;
    logic [N_CHAN-1:0]        trig_chans;
    logic [N_CHAN-1:0]        thresh_tot;
    logic                     busy;

    modport master (
        output adc_stream_in, gt, et, lt, thr, chan_en, coinc_k,
               thresh_trig_en, ext_trig_en, ext_run, run, holdoff,
        input  adc_stream_out, trig, trig_src, trig_chans, thresh_tot, busy
    );

    modport slave (
        input  adc_stream_in, gt, et, lt, thr, chan_en, coinc_k,
               thresh_trig_en, ext_trig_en, ext_run, run, holdoff,
        output adc_stream_out, trig, trig_src, trig_chans, thresh_tot, busy
    );
endinterface

// File: rtl/cuppa_trigger_nch.sv
// cuppa_trigger_nch
//   N-channel trigger block. Forwards every ADC stream with one cycle of
//   delay and issues a single-cycle trigger from one of three sources:
//   external run edge (highest), k-of-N threshold coincidence edge, software
//   run edge (lowest). An optional holdoff blocks all sources after a trigger.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cuppa_trigger_nch_if.slave (samples, config, trigger results)
// Build option:
//   TRIG_HOLDOFF_EN : when defined, the holdoff counter and busy are built;
//                     otherwise holdoff is ignored and busy is tied low.

// Per-channel comparator against the shared threshold.
module cuppa_trigger_chan #(
    parameter int DATA_W = 12
) (
    input  logic [DATA_W-1:0] s,
    input  logic [DATA_W-1:0] thr,
    input  logic              gt,
    input  logic              et,
    input  logic              lt,
    output logic              match
);
    assign match = (gt && (s > thr)) || (et && (s == thr)) || (lt && (s < thr));
endmodule

module cuppa_trigger_nch #(
    parameter int N_CHAN    = 4,
    parameter int DATA_W    = 12,
    parameter int HOLDOFF_W = 16,
    parameter int K_W       = $clog2(N_CHAN + 1)
) (
    input logic                clk,
    input logic                rst_n,
    cuppa_trigger_nch_if.slave bus
);
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_THR  = 2'd1;
    localparam logic [1:0] SRC_EXT  = 2'd2;
    localparam logic [1:0] SRC_SW   = 2'd3;

    logic [N_CHAN-1:0]        m;
    logic [N_CHAN-1:0]        em;
    logic [K_W-1:0]           em_cnt;
    logic [K_W-1:0]           k_eff;
    logic                     cond;
    logic                     thr_ev, ext_ev, sw_ev;
    logic                     blocked;
    logic [1:0]               src;

    logic [N_CHAN*DATA_W-1:0] adc_q;
    logic [N_CHAN-1:0]        tot_q;
    logic [N_CHAN-1:0]        chans_q;
    logic                     cond_q, ext_q, run_q;
    logic                     trig_q;
    logic [1:0]               src_q;
    logic                     busy_q;

    genvar c;
    generate
        for (c = 0; c < N_CHAN; c++) begin : g_chan
            cuppa_trigger_chan #(.DATA_W(DATA_W)) u_chan (
                .s     (bus.adc_stream_in[c*DATA_W +: DATA_W]),
                .thr   (bus.thr),
                .gt    (bus.gt),
                .et    (bus.et),
                .lt    (bus.lt),
                .match (m[c])
            );
        end
    endgenerate

    assign em = m & bus.chan_en;

    // K_W is wide enough to hold N_CHAN, so the count cannot overflow.
    always_comb begin
        em_cnt = '0;
        for (int i = 0; i < N_CHAN; i++) em_cnt = em_cnt + K_W'(em[i]);
    end

    assign k_eff  = (bus.coinc_k == '0) ? K_W'(1) : bus.coinc_k;
    assign cond   = bus.thresh_trig_en && (em_cnt >= k_eff);
    assign thr_ev = cond && !cond_q;
    assign ext_ev = bus.ext_trig_en && bus.ext_run && !ext_q;
    assign sw_ev  = bus.run && !run_q;

    // Losing events in the same cycle, and anything during holdoff, are dropped.
    always_comb begin
        src = SRC_NONE;
        if (!blocked) begin
            if (ext_ev)      src = SRC_EXT;
            else if (thr_ev) src = SRC_THR;
            else if (sw_ev)  src = SRC_SW;
        end
    end

`ifdef TRIG_HOLDOFF_EN
    logic [HOLDOFF_W-1:0] hcnt;

    // hcnt loads at the edge that raises trig, so it is nonzero exactly for
    // the holdoff edges that must be ignored. busy is that state registered
    // once more so it rises the cycle after the trig pulse, not with it.
    assign blocked = (hcnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt   <= '0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= (hcnt != '0);
            if (src != SRC_NONE)  hcnt <= bus.holdoff;
            else if (hcnt != '0)  hcnt <= hcnt - 1'b1;
        end
    end
`else
    logic unused_holdoff;
    assign unused_holdoff = ^bus.holdoff;
    assign blocked        = 1'b0;
    assign busy_q         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_q   <= '0;
            tot_q   <= '0;
            chans_q <= '0;
            cond_q  <= 1'b0;
            ext_q   <= 1'b0;
            run_q   <= 1'b0;
            trig_q  <= 1'b0;
            src_q   <= SRC_NONE;
        end else begin
            adc_q  <= bus.adc_stream_in;
            tot_q  <= m;
            // Edge history tracks the raw levels even while blocked.
            cond_q <= cond;
            ext_q  <= bus.ext_run;
            run_q  <= bus.run;
            trig_q <= (src != SRC_NONE);
            src_q  <= src;
            if (src != SRC_NONE) chans_q <= em;
        end
    end

    assign bus.adc_stream_out = adc_q;
    assign bus.thresh_tot     = tot_q;
    assign bus.trig           = trig_q;
    assign bus.trig_src       = src_q;
    assign bus.trig_chans     = chans_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_cuppa_trigger_nch.sv
module tb_cuppa_trigger_nch;
    localparam int N  = 4;
    localparam int DW = 12;
    localparam int HW = 16;
    localparam int KW = $clog2(N + 1);

    typedef struct packed {
        logic [N*DW-1:0] adc;
        logic [N-1:0]    tot;
        logic            trig;
        logic [1:0]      src;
        logic [N-1:0]    chans;
        logic            busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cuppa_trigger_nch_if #(.N_CHAN(N), .DATA_W(DW), .HOLDOFF_W(HW), .K_W(KW)) bus ();

    cuppa_trigger_nch #(.N_CHAN(N), .DATA_W(DW), .HOLDOFF_W(HW), .K_W(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state: previous levels and trigger history.
    bit          m_cond_q, m_ext_q, m_run_q;
    bit          have_fire;
    int          edge_n, last_fire, last_h;
    logic [N-1:0] m_chans;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_cond_q = 0; m_ext_q = 0; m_run_q = 0;
        have_fire = 0; edge_n = 0; last_fire = 0; last_h = 0; m_chans = '0;
    endtask

    // Called at each rising edge with reset released; inputs are the values
    // the bench is driving, so this is what the block sees at this edge.
    task automatic model_edge();
        exp_t         x;
        logic [N-1:0] mm, em;
        logic [DW-1:0] sv;
        int           cnt, k;
        bit           cond, te, ee, se, blk;
        for (int c = 0; c < N; c++) begin
            sv = bus.adc_stream_in[c*DW +: DW];
            mm[c] = (bus.gt && sv > bus.thr) || (bus.et && sv == bus.thr) || (bus.lt && sv < bus.thr);
        end
        em   = mm & bus.chan_en;
        cnt  = $countones(em);
        k    = (bus.coinc_k == 0) ? 1 : int'(bus.coinc_k);
        cond = bus.thresh_trig_en && (cnt >= k);
        te   = cond && !m_cond_q;
        ee   = bus.ext_trig_en && bus.ext_run && !m_ext_q;
        se   = bus.run && !m_run_q;
`ifdef TRIG_HOLDOFF_EN
        // Edges within holdoff cycles after the last trigger are ignored.
        blk = have_fire && ((edge_n - last_fire) <= last_h);
`else
        blk = 0;
`endif
        x.adc  = bus.adc_stream_in;
        x.tot  = mm;
        x.busy = blk;
        x.src  = blk ? 2'd0 : ee ? 2'd2 : te ? 2'd1 : se ? 2'd3 : 2'd0;
        x.trig = (x.src != 0);
        if (x.trig) begin
            have_fire = 1;
            last_fire = edge_n;
            last_h    = int'(bus.holdoff);
            m_chans   = em;
        end
        x.chans  = m_chans;
        m_cond_q = cond;
        m_ext_q  = bus.ext_run;
        m_run_q  = bus.run;
        edge_n++;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " adc_stream_out"}, 64'(bus.adc_stream_out), 64'd0);
        chk({tag, " trig"},           64'(bus.trig),           64'd0);
        chk({tag, " trig_src"},       64'(bus.trig_src),       64'd0);
        chk({tag, " trig_chans"},     64'(bus.trig_chans),     64'd0);
        chk({tag, " thresh_tot"},     64'(bus.thresh_tot),     64'd0);
        chk({tag, " busy"},           64'(bus.busy),           64'd0);
    endtask

    // Monitor: every cycle the block presents a full output set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("adc_stream_out", 64'(bus.adc_stream_out), 64'(e.adc));
                chk("thresh_tot",     64'(bus.thresh_tot),     64'(e.tot));
                chk("trig",           64'(bus.trig),           64'(e.trig));
                chk("trig_src",       64'(bus.trig_src),       64'(e.src));
                chk("trig_chans",     64'(bus.trig_chans),     64'(e.chans));
                chk("busy",           64'(bus.busy),           64'(e.busy));
            end
        end
    end

    logic [DW-1:0]   cur [N];
    logic [N*DW-1:0] packed_adc;

    task automatic drive_adc();
        for (int c = 0; c < N; c++) packed_adc[c*DW +: DW] = cur[c];
        bus.adc_stream_in = packed_adc;
    endtask

    function automatic logic [DW-1:0] pick(input logic [DW-1:0] t);
        case ($urandom_range(0, 3))
            0:       return t - 1'b1;
            1:       return t;
            2:       return t + 1'b1;
            default: return DW'($urandom_range(0, (1 << DW) - 1));
        endcase
    endfunction

    initial begin
        model_reset();
        for (int c = 0; c < N; c++) cur[c] = '0;
        drive_adc();
        bus.gt = 1; bus.et = 0; bus.lt = 0; bus.thr = 12'd100;
        bus.chan_en = '1; bus.coinc_k = '0; bus.thresh_trig_en = 0;
        bus.ext_trig_en = 0; bus.ext_run = 0; bus.run = 0; bus.holdoff = '0;
        #12;
        check_zero("reset");
        @(negedge clk); #1 rst_n = 1'b1;

        // Randomized segments with varied configuration.
        for (int seg = 0; seg < 14; seg++) begin
            step();
            bus.thr            = DW'($urandom_range(1, (1 << DW) - 2));
            {bus.gt, bus.et, bus.lt} = 3'($urandom_range(0, 7));
            bus.chan_en        = N'($urandom_range(0, (1 << N) - 1));
            bus.coinc_k        = KW'($urandom_range(0, N));
            bus.thresh_trig_en = ($urandom_range(0, 3) != 0);
            bus.ext_trig_en    = $urandom_range(0, 1);
            bus.holdoff        = (seg % 3 == 0) ? '0 : HW'($urandom_range(1, 12));
            for (int i = 0; i < 150; i++) begin
                step();
                for (int c = 0; c < N; c++)
                    if ($urandom_range(0, 3) == 0) cur[c] = pick(bus.thr);
                drive_adc();
                if ($urandom_range(0, 5) == 0) bus.ext_run = ~bus.ext_run;
                if ($urandom_range(0, 5) == 0) bus.run = ~bus.run;
                if ($urandom_range(0, 19) == 0) bus.holdoff = HW'($urandom_range(0, 12));
            end
        end

        // holdoff 0 with ext_run toggling every cycle.
        step();
        bus.holdoff = '0; bus.ext_trig_en = 1; bus.thresh_trig_en = 0; bus.run = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            bus.ext_run = ~bus.ext_run;
        end

        // Reset asserted three cycles into a 10-cycle holdoff.
        step();
        bus.ext_run = 0; bus.holdoff = HW'(10);
        step();
        bus.ext_run = 1;
        for (int i = 0; i < 4; i++) step();
        @(negedge clk); #1 rst_n = 1'b0;
        #1 check_zero("midreset");
        q.delete();
        model_reset();
        for (int i = 0; i < 3; i++) step();
        @(negedge clk); #1 rst_n = 1'b1;
        bus.ext_run = 0;
        step();
        bus.run = 1;
        for (int i = 0; i < 6; i++) step();

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
